// File: rtl/iu_pkg.sv
// Shared definitions for the warp issue unit: default warp count,
// lifecycle FSM state encoding and a one-hot to index helper.
package iu_pkg;

    localparam int NUM_WARPS = 8;
    localparam int WARP_ID_W = $clog2(NUM_WARPS);
    // Widest warp vector the helper function accepts.
    localparam int MAX_WARPS = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } iu_state_e;

    // OR-reduction encoder: exact for one-hot inputs, 0 for an all-zero input.
    function automatic int onehot_to_idx(input logic [MAX_WARPS-1:0] oh);
        int idx;
        idx = 0;
        for (int i = 0; i < MAX_WARPS; i++) begin
            if (oh[i]) begin
                idx = idx | i;
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/warp_issue_arbiter_if.sv
// Bundle of launch, IBuffer request/grant and OC handshake signals of the
// issue unit. master = IBuffers/launcher/OC side, slave = issue unit.
interface warp_issue_arbiter_if #(
    parameter int NUM_WARPS = iu_pkg::NUM_WARPS
);
    localparam int WARP_ID_W = $clog2(NUM_WARPS);

    logic                 Launch_Valid_IU;
    logic [NUM_WARPS-1:0] Launch_Mask_IU;
    logic [NUM_WARPS-1:0] Req_IB_IU;
    logic [NUM_WARPS-1:0] Exit_Req_IB_IU;
    logic                 OC_Full_OC_IU;
    logic [NUM_WARPS-1:0] Grt_IU_IB;
    logic [NUM_WARPS-1:0] Exit_Grt_IU_IB;
    logic                 Grt_Valid_IU_OC;
    logic [WARP_ID_W-1:0] Grt_WarpID_IU_OC;
    logic [NUM_WARPS-1:0] Active_Mask_IU;
    logic                 Busy_IU;
    logic                 Kernel_Done_IU;

    modport master (
        output Launch_Valid_IU, Launch_Mask_IU, Req_IB_IU, Exit_Req_IB_IU, OC_Full_OC_IU,
        input  Grt_IU_IB, Exit_Grt_IU_IB, Grt_Valid_IU_OC, Grt_WarpID_IU_OC,
        input  Active_Mask_IU, Busy_IU, Kernel_Done_IU
    );

    modport slave (
        input  Launch_Valid_IU, Launch_Mask_IU, Req_IB_IU, Exit_Req_IB_IU, OC_Full_OC_IU,
        output Grt_IU_IB, Exit_Grt_IU_IB, Grt_Valid_IU_OC, Grt_WarpID_IU_OC,
        output Active_Mask_IU, Busy_IU, Kernel_Done_IU
    );
endinterface

// File: rtl/rr_arbiter.sv
// Rotating-priority one-hot arbiter: the search starts at ptr and wraps
// around; N must be a power of two so the index addition wraps naturally.
module rr_arbiter #(
    parameter int N = 8,
    localparam int IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N-1:0]     gnt,
    output logic [IDX_W-1:0] gnt_idx,
    output logic             gnt_valid
);
    import iu_pkg::*;

    logic [IDX_W-1:0] cand;

    // Walk the requests from ptr upward and grant the first one found.
    always_comb begin
        gnt       = '0;
        gnt_valid = 1'b0;
        cand      = '0;
        for (int i = 0; i < N; i++) begin
            cand = ptr + IDX_W'(i);
            if (!gnt_valid && req[cand]) begin
                gnt_valid  = 1'b1;
                gnt[cand]  = 1'b1;
            end
        end
    end

    assign gnt_idx = IDX_W'(onehot_to_idx(16'(gnt)));

endmodule

// File: rtl/warp_issue_arbiter.sv
// Warp issue unit: grants one warp per cycle to the operand collector,
// grants at most one warp exit per cycle and tracks the IDLE/RUN/DONE
// kernel lifecycle. Optional macro IU_GTO_EN selects greedy-then-oldest
// issue; without it the issue policy is plain round-robin.
module warp_issue_arbiter #(
    parameter int NUM_WARPS = iu_pkg::NUM_WARPS,
    localparam int WARP_ID_W = $clog2(NUM_WARPS)
) (
    input  logic                 clk,
    input  logic                 rst,
    warp_issue_arbiter_if.slave  bus
);
    import iu_pkg::*;

    iu_state_e            state_reg, state_next;
    logic [NUM_WARPS-1:0] active_reg, active_next;
    logic [WARP_ID_W-1:0] ptr_reg, ptr_next;

    logic                 run;
    logic [NUM_WARPS-1:0] exit_elig, exit_gnt;
    logic [NUM_WARPS-1:0] issue_elig, issue_gnt;
    logic [WARP_ID_W-1:0] issue_idx;
    logic                 issue_valid;
    logic [NUM_WARPS-1:0] rr_gnt;
    logic [WARP_ID_W-1:0] rr_idx;
    logic                 rr_valid;
    logic                 hold_ptr;

    // Grants only exist in RUN and are forced off while reset is asserted.
    assign run        = rst && (state_reg == RUN);
    assign exit_elig  = bus.Exit_Req_IB_IU & active_reg & {NUM_WARPS{run}};
    // Exit beats issue for a warp requesting both.
    assign issue_elig = bus.Req_IB_IU & active_reg & ~bus.Exit_Req_IB_IU
                        & {NUM_WARPS{run && !bus.OC_Full_OC_IU}};

    // Fixed priority exit: a warp wins when no lower-index warp is eligible.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_WARPS; gi++) begin : g_exit_pri
            if (gi == 0) begin : g_first
                assign exit_gnt[gi] = exit_elig[gi];
            end else begin : g_rest
                assign exit_gnt[gi] = exit_elig[gi] & ~(|exit_elig[gi-1:0]);
            end
        end
    endgenerate

    rr_arbiter #(.N(NUM_WARPS)) u_issue_rr (
        .req       (issue_elig),
        .ptr       (ptr_reg),
        .gnt       (rr_gnt),
        .gnt_idx   (rr_idx),
        .gnt_valid (rr_valid)
    );

`ifdef IU_GTO_EN
    logic [WARP_ID_W-1:0] last_idx_reg, last_idx_next;
    logic                 last_valid_reg, last_valid_next;
    logic [NUM_WARPS-1:0] last_onehot;
    logic                 gto_hit;

    generate
        for (gi = 0; gi < NUM_WARPS; gi++) begin : g_last_oh
            assign last_onehot[gi] = (last_idx_reg == WARP_ID_W'(gi));
        end
    endgenerate

    // Stay greedy on the previously granted warp while it remains eligible.
    assign gto_hit     = last_valid_reg && |(issue_elig & last_onehot);
    assign issue_gnt   = gto_hit ? last_onehot : rr_gnt;
    assign issue_idx   = gto_hit ? last_idx_reg : rr_idx;
    assign issue_valid = gto_hit || rr_valid;
    assign hold_ptr    = gto_hit;

    // Remember the most recent issue grant; a new launch forgets it.
    always_comb begin
        last_idx_next   = last_idx_reg;
        last_valid_next = last_valid_reg;
        if (state_reg == IDLE && bus.Launch_Valid_IU) begin
            last_valid_next = 1'b0;
        end else if (issue_valid) begin
            last_idx_next   = issue_idx;
            last_valid_next = 1'b1;
        end
    end

    // Greedy-warp tracking registers.
    always_ff @(posedge clk) begin
        if (!rst) begin
            last_idx_reg   <= '0;
            last_valid_reg <= 1'b0;
        end else begin
            last_idx_reg   <= last_idx_next;
            last_valid_reg <= last_valid_next;
        end
    end
`else
    assign issue_gnt   = rr_gnt;
    assign issue_idx   = rr_idx;
    assign issue_valid = rr_valid;
    assign hold_ptr    = 1'b0;
`endif

    // Lifecycle next state, live-warp mask and round-robin pointer update.
    always_comb begin
        state_next  = state_reg;
        active_next = active_reg;
        ptr_next    = ptr_reg;
        if (issue_valid && !hold_ptr) begin
            ptr_next = issue_idx + WARP_ID_W'(1);
        end
        case (state_reg)
            IDLE: begin
                if (bus.Launch_Valid_IU && (|bus.Launch_Mask_IU)) begin
                    state_next  = RUN;
                    active_next = bus.Launch_Mask_IU;
                end
            end
            RUN: begin
                active_next = active_reg & ~exit_gnt;
                if ((|exit_gnt) && (active_next == '0)) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_reg  <= IDLE;
            active_reg <= '0;
            ptr_reg    <= '0;
        end else begin
            state_reg  <= state_next;
            active_reg <= active_next;
            ptr_reg    <= ptr_next;
        end
    end

    assign bus.Grt_IU_IB        = issue_gnt;
    assign bus.Exit_Grt_IU_IB   = exit_gnt;
    assign bus.Grt_Valid_IU_OC  = issue_valid;
    assign bus.Grt_WarpID_IU_OC = issue_valid ? issue_idx : '0;
    assign bus.Active_Mask_IU   = active_reg;
    assign bus.Busy_IU          = (state_reg == RUN);
    assign bus.Kernel_Done_IU   = (state_reg == DONE);

endmodule
